// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter: default width,
// FSM state encoding and the bit-counter width helper.
package piso_serial_tx_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_serial_tx_bit_counter.sv
// Bit counter for the serial transmitter: synchronous clear, count enable and
// a terminal-count flag raised while the count equals WIDTH-1.
module tx_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter feeding a shift register's serial input;
// one word per load handshake, one bit per clock, framed by frame_out.
//
// Handshake: a load is accepted at a posedge where load_valid && load_ready;
// load_ready is high only in IDLE, and load_valid while busy is dropped.
module piso_serial_tx
  import piso_serial_tx_pkg::*;
#(
  parameter  int WIDTH     = WIDTH_DEFAULT,
  parameter  bit LSB_FIRST = 1'b1,
  localparam int CW        = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame_out,
  output logic             done,
  output logic [CW-1:0]    bit_count,
  output logic [1:0]       state_dbg
);

  localparam int OUT_BIT = LSB_FIRST ? 0 : WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             load_ready_q, load_ready_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             accept;
  logic             cnt_en;
  logic             cnt_tc;

  assign accept = (state_q == ST_IDLE) && load_valid;
  assign cnt_en = (state_q == ST_SHIFT);

  tx_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (cnt_en),
    .count (bit_count),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    load_ready_d = load_ready_q;
    frame_d      = frame_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ready_d = 1'b1;
        frame_d      = 1'b0;
        if (load_valid) begin
          sreg_d       = in_data;
          state_d      = ST_SHIFT;
          load_ready_d = 1'b0;
          frame_d      = 1'b1;
        end
      end
      ST_SHIFT: begin
        sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
        if (cnt_tc) begin
          state_d      = ST_DONE;
          frame_d      = 1'b0;
          done_d       = 1'b1;
          load_ready_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        load_ready_d = 1'b1;
        frame_d      = 1'b0;
      end
      default: begin
        // Unused encoding 2'd3: fall back to a clean idle.
        state_d      = ST_IDLE;
        sreg_d       = '0;
        load_ready_d = 1'b1;
        frame_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      load_ready_q <= 1'b1;
      frame_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      load_ready_q <= load_ready_d;
      frame_q      <= frame_d;
      done_q       <= done_d;
    end
  end

  assign load_ready = load_ready_q;
  assign frame_out  = frame_q;
  assign done       = done_q;
  assign serial_out = frame_q & sreg_q[OUT_BIT];
  assign state_dbg  = state_q;

endmodule
